uart_wb_scheduler: RTL and testbench

- Wishbone master that owns the 8N1 UART core's two-register slave port (addr 0 = data, addr 1 = status).
- Shares the transmitter between two byte-stream requesters using round-robin arbitration.
- Drains received bytes into a valid/ready output.
- Sits between the UART core and on-chip producers/consumers, replacing CPU polling of the status register.

---
 rtl/uart_sched_pkg.sv | 26 ++
 rtl/uart_wb_scheduler_rr_arb2.sv | 44 ++++
 rtl/uart_wb_scheduler.sv | 169 ++++++++++++++++
 tb/tb_uart_wb_scheduler.sv | 247 ++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_sched_pkg.sv
// Shared types and constants for the UART Wishbone scheduler.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package uart_sched_pkg;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        POLL     = 2'd1,
        RX_READ  = 2'd2,
        TX_WRITE = 2'd3
    } state_t;

    // UART slave register map
    localparam logic ADR_DATA = 1'b0;
    localparam logic ADR_STAT = 1'b1;

    // Status register bit positions
    localparam int ST_TXRDY = 0;
    localparam int ST_RXAV  = 1;

    // Width of the inter-poll gap counter; never narrower than one bit.
    function automatic int gap_width(input int gap);
        return (gap < 1) ? 1 : $clog2(gap + 1);
    endfunction

endpackage

// File: rtl/uart_wb_scheduler_rr_arb2.sv
// Two-way arbiter choosing which transmit requester gets the UART.
// Latency: grant is combinational from req; pointer updates one cycle after upd.
// Backpressure: none; the caller decides when a grant is consumed (upd).
//
// Ports: clk/rst (async active-high), req[1:0] requests, upd strobe with
// upd_idx = index actually served, gnt = winning index.
// Build option UART_SCHED_FIXED_PRIO_EN: requester 0 always wins, no pointer.
module rr_arb2 (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] req,
    input  logic       upd,
    input  logic       upd_idx,
    output logic       gnt
);

`ifdef UART_SCHED_FIXED_PRIO_EN
    // Requester 0 wins whenever present; otherwise requester 1.
    assign gnt = ~req[0];

    logic unused_fixed;
    assign unused_fixed = ^{clk, rst, upd, upd_idx, req[1]};
`else
    logic last;   // index granted most recently

    // Reset to 1 so that requester 0 wins the first tie.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            last <= 1'b1;
        end else if (upd) begin
            last <= upd_idx;
        end
    end

    always_comb begin
        if (req == 2'b11) begin
            gnt = ~last;
        end else begin
            gnt = req[1];
        end
    end
`endif

endmodule

// File: rtl/uart_wb_scheduler.sv
// Wishbone master that polls an 8N1 UART, shares its TX between two requesters
// and drains RX bytes. Latency: one status poll per 2+POLL_GAP cycles; a data
// access follows a poll after one idle cycle. Backpressure: rx_rdy_i low blocks data reads.
//
// Ports: wb_clk_i/wb_rst_i (async active-high); m_* Wishbone master to the UART
// (adr 0 data, adr 1 status); txN_req_i/txN_dat_i in, txN_ack_o pulse out;
// rx_dat_o/rx_vld_o/rx_rdy_i receive stream.
// Build option UART_SCHED_FIXED_PRIO_EN: fixed priority, requester 0 first.
module uart_wb_scheduler
    import uart_sched_pkg::*;
#(
    parameter int POLL_GAP = 0
) (
    input  logic       wb_clk_i,
    input  logic       wb_rst_i,
    output logic       m_adr_o,
    output logic [7:0] m_dat_o,
    input  logic [7:0] m_dat_i,
    output logic       m_we_o,
    output logic       m_stb_o,
    input  logic       m_ack_i,
    input  logic       tx0_req_i,
    input  logic [7:0] tx0_dat_i,
    output logic       tx0_ack_o,
    input  logic       tx1_req_i,
    input  logic [7:0] tx1_dat_i,
    output logic       tx1_ack_o,
    output logic [7:0] rx_dat_o,
    output logic       rx_vld_o,
    input  logic       rx_rdy_i
);

    localparam int GW = gap_width(POLL_GAP);
    localparam logic [GW-1:0] GAP_MAX = GW'(POLL_GAP);

    state_t        state, state_nxt;
    logic [GW-1:0] gap_cnt, gap_nxt;
    logic          adr_nxt, we_nxt, stb_nxt;
    logic [7:0]    dat_nxt;
    logic          ack0_nxt, ack1_nxt;
    logic [7:0]    rx_dat_nxt;
    logic          rx_vld_nxt;
    logic          gnt_idx, gnt_idx_nxt;
    logic          arb_gnt;
    logic          arb_upd;
    logic          acked;

    // An ack only counts while we are strobing.
    assign acked = m_stb_o & m_ack_i;

    rr_arb2 u_arb (
        .clk     (wb_clk_i),
        .rst     (wb_rst_i),
        .req     ({tx1_req_i, tx0_req_i}),
        .upd     (arb_upd),
        .upd_idx (gnt_idx),
        .gnt     (arb_gnt)
    );

    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            state     <= IDLE;
            gap_cnt   <= '0;
            m_adr_o   <= 1'b0;
            m_dat_o   <= 8'h00;
            m_we_o    <= 1'b0;
            m_stb_o   <= 1'b0;
            tx0_ack_o <= 1'b0;
            tx1_ack_o <= 1'b0;
            rx_dat_o  <= 8'h00;
            rx_vld_o  <= 1'b0;
            gnt_idx   <= 1'b0;
        end else begin
            state     <= state_nxt;
            gap_cnt   <= gap_nxt;
            m_adr_o   <= adr_nxt;
            m_dat_o   <= dat_nxt;
            m_we_o    <= we_nxt;
            m_stb_o   <= stb_nxt;
            tx0_ack_o <= ack0_nxt;
            tx1_ack_o <= ack1_nxt;
            rx_dat_o  <= rx_dat_nxt;
            rx_vld_o  <= rx_vld_nxt;
            gnt_idx   <= gnt_idx_nxt;
        end
    end

    always_comb begin
        state_nxt   = state;
        gap_nxt     = gap_cnt;
        adr_nxt     = m_adr_o;
        dat_nxt     = m_dat_o;
        we_nxt      = m_we_o;
        stb_nxt     = m_stb_o;
        ack0_nxt    = 1'b0;
        ack1_nxt    = 1'b0;
        rx_dat_nxt  = rx_dat_o;
        rx_vld_nxt  = rx_vld_o;
        gnt_idx_nxt = gnt_idx;
        arb_upd     = 1'b0;

        if (rx_vld_o && rx_rdy_i) begin
            rx_vld_nxt = 1'b0;
        end

        case (state)
            IDLE: begin
                // IDLE is always at least one strobe-low cycle, so the
                // status read can be launched on leaving it.
                if (gap_cnt == GAP_MAX) begin
                    gap_nxt   = '0;
                    state_nxt = POLL;
                    stb_nxt   = 1'b1;
                    adr_nxt   = ADR_STAT;
                    we_nxt    = 1'b0;
                end else begin
                    gap_nxt = gap_cnt + 1'b1;
                end
            end

            POLL: begin
                if (acked) begin
                    stb_nxt = 1'b0;
                    if (m_dat_i[ST_RXAV] && !rx_vld_o) begin
                        state_nxt = RX_READ;
                    end else if (m_dat_i[ST_TXRDY] && (tx0_req_i || tx1_req_i)) begin
                        // Byte is captured at grant; later req changes do not matter.
                        state_nxt   = TX_WRITE;
                        gnt_idx_nxt = arb_gnt;
                        dat_nxt     = arb_gnt ? tx1_dat_i : tx0_dat_i;
                    end else begin
                        state_nxt = IDLE;
                    end
                end
            end

            RX_READ: begin
                // First cycle here is the idle gap after the poll.
                if (!m_stb_o) begin
                    stb_nxt = 1'b1;
                    adr_nxt = ADR_DATA;
                    we_nxt  = 1'b0;
                end else if (m_ack_i) begin
                    stb_nxt    = 1'b0;
                    rx_dat_nxt = m_dat_i;
                    rx_vld_nxt = 1'b1;
                    state_nxt  = IDLE;
                end
            end

            TX_WRITE: begin
                if (!m_stb_o) begin
                    stb_nxt = 1'b1;
                    adr_nxt = ADR_DATA;
                    we_nxt  = 1'b1;
                end else if (m_ack_i) begin
                    stb_nxt   = 1'b0;
                    ack0_nxt  = ~gnt_idx;
                    ack1_nxt  = gnt_idx;
                    arb_upd   = 1'b1;
                    state_nxt = IDLE;
                end
            end

            default: state_nxt = IDLE;
        endcase
    end

endmodule

// File: tb/tb_uart_wb_scheduler.sv
// Directed bench for uart_wb_scheduler with a behavioural UART slave model.
module tb_uart_wb_scheduler;

    logic       clk = 1'b0;
    logic       rst;
    logic       m_adr_o;
    logic [7:0] m_dat_o;
    logic [7:0] m_dat_i;
    logic       m_we_o;
    logic       m_stb_o;
    logic       m_ack_i;
    logic       tx0_req, tx1_req;
    logic [7:0] tx0_dat, tx1_dat;
    logic       tx0_ack_o, tx1_ack_o;
    logic [7:0] rx_dat_o;
    logic       rx_vld_o;
    logic       rx_rdy;

    // slave model controls
    logic [7:0] status;
    logic [7:0] rx_byte;
    int         ack_dly = 0;
    int         stb_cnt = 0;
    logic       spur_ack;

    int n_checks = 0;
    int n_errors = 0;

    // monitor state
    logic [8:0] acc_q[$];   // data-register accesses: {we, byte}
    int         ack_q[$];   // order of requester acks
    int         n_polls = 0;
    int         ack0_cnt = 0;
    int         ack1_cnt = 0;
    int         n_wcyc = 0;
    int         proto_err = 0;
    logic       p_stb = 1'b0, p_acked = 1'b0, p_ack0 = 1'b0, p_ack1 = 1'b0;
    logic [9:0] p_bus = '0;

    always #5 clk = ~clk;

    uart_wb_scheduler #(.POLL_GAP(0)) dut (
        .wb_clk_i  (clk),
        .wb_rst_i  (rst),
        .m_adr_o   (m_adr_o),
        .m_dat_o   (m_dat_o),
        .m_dat_i   (m_dat_i),
        .m_we_o    (m_we_o),
        .m_stb_o   (m_stb_o),
        .m_ack_i   (m_ack_i),
        .tx0_req_i (tx0_req),
        .tx0_dat_i (tx0_dat),
        .tx0_ack_o (tx0_ack_o),
        .tx1_req_i (tx1_req),
        .tx1_dat_i (tx1_dat),
        .tx1_ack_o (tx1_ack_o),
        .rx_dat_o  (rx_dat_o),
        .rx_vld_o  (rx_vld_o),
        .rx_rdy_i  (rx_rdy)
    );

    // UART slave: combinational ack, optionally delayed on writes.
    assign m_ack_i = (m_stb_o && (m_we_o ? (stb_cnt == ack_dly) : 1'b1)) || spur_ack;
    assign m_dat_i = m_adr_o ? status : rx_byte;

    always @(posedge clk) begin
        if (m_stb_o && !m_ack_i) stb_cnt <= stb_cnt + 1;
        else                     stb_cnt <= 0;
    end

    // Bus monitor: logs accesses and acks, flags protocol violations.
    always @(negedge clk) begin
        if (m_stb_o && m_ack_i) begin
            if (m_adr_o == 1'b0) acc_q.push_back({m_we_o, (m_we_o ? m_dat_o : m_dat_i)});
            else                 n_polls++;
        end
        if (m_stb_o && m_we_o) n_wcyc++;
        if (tx0_ack_o) begin ack0_cnt++; ack_q.push_back(0); if (p_ack0) proto_err++; end
        if (tx1_ack_o) begin ack1_cnt++; ack_q.push_back(1); if (p_ack1) proto_err++; end
        if (tx0_ack_o && tx1_ack_o) proto_err++;
        if (p_acked && m_stb_o) proto_err++;
        if (p_stb && !p_acked && m_stb_o && ({m_adr_o, m_we_o, m_dat_o} != p_bus)) proto_err++;
        p_stb   = m_stb_o;
        p_acked = m_stb_o && m_ack_i;
        p_ack0  = tx0_ack_o;
        p_ack1  = tx1_ack_o;
        p_bus   = {m_adr_o, m_we_o, m_dat_o};
    end

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // advance n cycles, land just after the falling edge
    task automatic step(input int n);
        repeat (n) @(negedge clk);
        #1;
    endtask

    initial begin
        int b0, b1, ba, bq, np, bw;
        logic [7:0] exp_d[4];
        int         exp_i[4];

        rst      = 1'b1;
        tx0_req  = 1'b0;
        tx1_req  = 1'b0;
        tx0_dat  = 8'h00;
        tx1_dat  = 8'h00;
        rx_rdy   = 1'b0;
        status   = 8'h00;
        rx_byte  = 8'h00;
        spur_ack = 1'b0;

        // ---- reset state
        #1;
        check_val("rst_outs", {m_adr_o, m_dat_o, m_we_o, m_stb_o, tx0_ack_o, tx1_ack_o,
                               rx_dat_o, rx_vld_o}, 0);
        step(3);

        // ---- both requesters, round-robin from reset
        status  = 8'h01;
        tx0_dat = 8'hA0;
        tx1_dat = 8'hB1;
        tx0_req = 1'b1;
        tx1_req = 1'b1;
        ba = acc_q.size();
        bq = ack_q.size();
        rst = 1'b0;
        step(1);
        check_val("first_poll", {m_stb_o, m_adr_o, m_we_o}, 3'b110);
        for (int i = 0; i < 200 && (acc_q.size() - ba) < 4; i++) step(1);
        tx0_req = 1'b0;
        tx1_req = 1'b0;
        step(10);
`ifdef UART_SCHED_FIXED_PRIO_EN
        exp_d = '{8'hA0, 8'hA0, 8'hA0, 8'hA0};
        exp_i = '{0, 0, 0, 0};
`else
        exp_d = '{8'hA0, 8'hB1, 8'hA0, 8'hB1};
        exp_i = '{0, 1, 0, 1};
`endif
        check_val("rr_nwrites", acc_q.size() - ba, 4);
        check_val("rr_nacks", ack_q.size() - bq, 4);
        for (int i = 0; i < 4; i++) begin
            if (acc_q.size() > ba + i) check_val($sformatf("rr_wr%0d", i), acc_q[ba + i], {1'b1, exp_d[i]});
            if (ack_q.size() > bq + i) check_val($sformatf("rr_ack%0d", i), ack_q[bq + i], exp_i[i]);
        end

        // ---- single requester 0
        tx0_dat = 8'h41;
        tx0_req = 1'b1;
        b0 = ack0_cnt; b1 = ack1_cnt; ba = acc_q.size();
        for (int i = 0; i < 50 && ack0_cnt == b0; i++) step(1);
        tx0_req = 1'b0;
        step(10);
        check_val("t1_ack0", ack0_cnt - b0, 1);
        check_val("t1_ack1", ack1_cnt - b1, 0);
        check_val("t1_nacc", acc_q.size() - ba, 1);
        if (acc_q.size() > ba) check_val("t1_wr", acc_q[ba], {1'b1, 8'h41});

        // ---- RX has priority over TX within a poll
        status  = 8'h03;
        rx_byte = 8'h5A;
        tx0_dat = 8'h77;
        tx0_req = 1'b1;
        b0 = ack0_cnt; ba = acc_q.size();
        for (int i = 0; i < 100 && ack0_cnt == b0; i++) step(1);
        tx0_req = 1'b0;
        step(10);
        check_val("t3_ack0", ack0_cnt - b0, 1);
        check_val("t3_nacc", acc_q.size() - ba, 2);
        if (acc_q.size() > ba)     check_val("t3_rd_first", acc_q[ba], {1'b0, 8'h5A});
        if (acc_q.size() > ba + 1) check_val("t3_wr_second", acc_q[ba + 1], {1'b1, 8'h77});
        check_val("t3_rx", {rx_vld_o, rx_dat_o}, {1'b1, 8'h5A});

        // ---- rx_vld held: only status polls
        status  = 8'h02;
        rx_byte = 8'hC3;
        ba = acc_q.size(); np = n_polls;
        step(20);
        check_val("t4_no_data_rd", acc_q.size() - ba, 0);
        check_val("t4_polls", (n_polls - np) >= 5, 1);
        check_val("t4_vld_held", rx_vld_o, 1);
        rx_rdy = 1'b1;
        step(1);
        check_val("t4_vld_clr", rx_vld_o, 0);
        rx_rdy = 1'b0;
        for (int i = 0; i < 50 && !rx_vld_o; i++) step(1);
        check_val("t4_rx", {rx_vld_o, rx_dat_o}, {1'b1, 8'hC3});
        if (acc_q.size() > ba) check_val("t4_rd", acc_q[ba], {1'b0, 8'hC3});

        // ---- slow slave on write: 4 stable strobe cycles
        status  = 8'h01;
        ack_dly = 3;
        tx1_dat = 8'h9C;
        tx1_req = 1'b1;
        b0 = ack0_cnt; b1 = ack1_cnt; ba = acc_q.size(); bw = n_wcyc;
        for (int i = 0; i < 100 && ack1_cnt == b1; i++) step(1);
        tx1_req = 1'b0;
        step(5);
        check_val("t5_wcycles", n_wcyc - bw, 4);
        check_val("t5_ack1", ack1_cnt - b1, 1);
        check_val("t5_ack0", ack0_cnt - b0, 0);
        if (acc_q.size() > ba) check_val("t5_wr", acc_q[ba], {1'b1, 8'h9C});
        check_val("t5_proto", proto_err, 0);

        // ---- reset in the middle of a write
        tx0_dat = 8'h55;
        tx0_req = 1'b1;
        b0 = ack0_cnt;
        for (int i = 0; i < 100 && !(m_stb_o && m_we_o); i++) step(1);
        check_val("t6_in_write", m_stb_o && m_we_o, 1);
        #2;
        rst = 1'b1;
        #1;
        check_val("t6_async_stb", m_stb_o, 0);
        check_val("t6_outs", {m_adr_o, m_dat_o, m_we_o, tx0_ack_o, tx1_ack_o, rx_dat_o, rx_vld_o}, 0);
        tx0_req = 1'b0;
        ack_dly = 0;
        step(2);
        rst = 1'b0;
        step(1);
        check_val("t6_first_poll", {m_stb_o, m_adr_o}, 2'b11);
        step(10);
        check_val("t6_no_ack", ack0_cnt - b0, 0);

        // ---- ack held high with nothing pending
        status   = 8'h00;
        spur_ack = 1'b1;
        ba = acc_q.size(); b0 = ack0_cnt; b1 = ack1_cnt;
        step(12);
        spur_ack = 1'b0;
        step(4);
        check_val("t7_no_acc", acc_q.size() - ba, 0);
        check_val("t7_no_acks", (ack0_cnt - b0) + (ack1_cnt - b1), 0);
        check_val("proto_err", proto_err, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
